mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage pipeline. Consumes EX results (wd/wreg/wdata) plus load/store info and drives
//  a single-outstanding req/ack data bus. Registers the writeback triple for MEM/WB and stalls the
//  upstream pipeline while a bus access is pending. Non-memory ops pass through with 1-cycle latency.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles waiting for bus_ack_i (used only with BUS_TIMEOUT_EN)
// PORTS
//  clk          in   1   single clock; all state changes on rising edge
//  rst          in   1   asynchronous, active-low reset (asserted when rst==1'b0)
//  valid_i      in   1   EX outputs below are valid this cycle
//  wd_i         in   5   destination register address
//  wreg_i       in   1   register write enable from EX
//  wdata_i      in   32  EX result (writeback data for non-load ops)
//  mem_op_i     in   4   0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW; 9-15 treated as NONE
//  mem_addr_i   in   32  effective address
//  mem_data_i   in   32  store data (rt)
//  stall_o      out  1   upstream must hold all *_i inputs stable
//  wd_o         out  5   registered dest addr to MEM/WB
//  wreg_o       out  1   registered write enable
//  wdata_o      out  32  registered writeback data
//  align_err_o  out  1   1-cycle pulse: misaligned access dropped
//  bus_req_o    out  1   bus request, held until ack
//  bus_we_o     out  1   1 = store
//  bus_addr_o   out  32  word-aligned address ({addr[31:2],2'b00})
//  bus_sel_o    out  4   byte lanes, bit3 = bits[31:24]
//  bus_wdata_o  out  32  store data, replicated into lanes
//  bus_rdata_i  in   32  read data, valid with ack
//  bus_ack_i    in   1   transfer complete
// BEHAVIOUR
//  Reset: state IDLE; every output 0 (stall_o combinationally 0 during reset).
//  FSM IDLE/BUSY. IDLE + valid_i + op NONE: next edge wd_o/wreg_o/wdata_o <= inputs.
//  IDLE + valid_i + aligned mem op: stall_o=1 combinationally; next edge -> BUSY, bus_* registered.
//  IDLE + !valid_i: next edge wreg_o<=0 (bubble); wd_o/wdata_o hold.
//  BUSY: bus_req_o=1, bus_* stable; stall_o = !bus_ack_i (combinational path ack->stall is required).
//  BUSY + ack: same edge -> IDLE, bus_req_o<=0, writeback regs loaded; upstream advances same edge.
//  Back-to-back: new mem op accepted in IDLE cycle after ack; min 2 cycles per access, no bus idle skip.
//  Big-endian lanes: addr[1:0]=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
//  SB sel=one-hot lane, wdata={4{b}}; SH sel 1100/0011, wdata={2{h}}; SW sel 1111.
//  Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW full word; wreg_o=wreg_i, wdata_o=extracted.
//  Stores: wreg_o<=0 on completion.
//  Alignment: LH/LHU/SH need addr[0]=0, LW/SW need addr[1:0]=0. Else no bus access, no stall,
//   next edge wreg_o<=0, align_err_o<=1 for one cycle.
//  Reset mid-BUSY: immediate IDLE, bus_req_o=0 (bus owner tolerates abandoned request).
//  Inputs changing while stall_o=1 are a protocol violation; block uses values latched at accept.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: 8+ bit counter cleared on entering BUSY, increments each BUSY cycle w/o ack;
//   reaching TIMEOUT_CYCLES -> IDLE, bus_req_o<=0, wreg_o<=0, align_err_o pulses, stall_o drops that cycle.
//  Undefined: no counter; BUSY waits indefinitely for bus_ack_i.
// TESTING
//  ALU pass: valid, op NONE, wd=5, wreg=1, wdata=0x1234 -> next cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stall_o=0.
//  LB addr 0x103, rdata 0x000000F0, ack after 3 BUSY cycles -> sel=0001, stall 4 cycles, wdata_o=0xFFFFFFF0.
//  LHU addr 0x102, rdata 0x1234ABCD, ack 1st BUSY cycle -> sel=0011, wdata_o=0x0000ABCD, total 2 cycles.
//  SH addr 0x200, data 0x0000BEEF -> we=1, sel=1100, bus_wdata=0xBEEFBEEF, wreg_o=0 after ack.
//  LW addr 0x102 -> no bus_req, stall_o=0, align_err_o pulse, wreg_o=0; rst low mid-BUSY -> all outputs 0.
//  BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> req high 4 cycles, then drop, align_err_o pulse, stall released.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: single-outstanding req/ack data bus access plus MEM/WB writeback registers.
// Optional bus watchdog enabled with `define BUS_TIMEOUT_EN (TIMEOUT_CYCLES sets the limit).
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic        stall_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        align_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic        is_load, is_store, is_mem, aligned;
  logic [3:0]  sel_nxt;
  logic [31:0] bwdata_nxt;
  logic        accept, done, timeout_hit;

  // Latched at accept so the access ignores any upstream change while stalled
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic        is_load_q;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  // Request decode: lane select, store replication and alignment
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    aligned    = 1'b1;
    sel_nxt    = 4'b0000;
    bwdata_nxt = 32'h0;
    case (mem_op_i)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        sel_nxt = 4'b1000 >> mem_addr_i[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load = 1'b1;
        aligned = ~mem_addr_i[0];
        sel_nxt = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      end
      OP_LW: begin
        is_load = 1'b1;
        aligned = (mem_addr_i[1:0] == 2'b00);
        sel_nxt = 4'b1111;
      end
      OP_SB: begin
        is_store   = 1'b1;
        sel_nxt    = 4'b1000 >> mem_addr_i[1:0];
        bwdata_nxt = {4{mem_data_i[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        aligned    = ~mem_addr_i[0];
        sel_nxt    = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        bwdata_nxt = {2{mem_data_i[15:0]}};
      end
      OP_SW: begin
        is_store   = 1'b1;
        aligned    = (mem_addr_i[1:0] == 2'b00);
        sel_nxt    = 4'b1111;
        bwdata_nxt = mem_data_i;
      end
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

  assign accept = (state == IDLE) && valid_i && is_mem && aligned;
  assign done   = (state == BUSY) && bus_ack_i;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == BUSY && !bus_ack_i) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == BUSY) && !bus_ack_i &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: ack->stall is a deliberate combinational path so upstream advances on the ack edge
  always_comb begin
    stall_o = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    stall_o = accept;
        BUSY:    stall_o = !bus_ack_i && !timeout_hit;
        default: stall_o = 1'b0;
      endcase
    end
  end

  // Load data extraction, big-endian lane order
  assign is_load_q = (op_q >= OP_LB) && (op_q <= OP_LW);
  assign rd_byte   = 8'(bus_rdata_i >> {~off_q, 3'b000});
  assign rd_half   = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];

  always_comb begin
    case (op_q)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'h0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'h0, rd_half};
      default: load_data = bus_rdata_i;
    endcase
  end

  // Datapath, writeback and bus registers
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
      align_err_o <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      op_q        <= '0;
      off_q       <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
    end else begin
      align_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!valid_i) begin
            wreg_o <= 1'b0;
          end else if (!is_mem) begin
            wd_o    <= wd_i;
            wreg_o  <= wreg_i;
            wdata_o <= wdata_i;
          end else if (!aligned) begin
            wreg_o      <= 1'b0;
            align_err_o <= 1'b1;
          end else begin
            wreg_o      <= 1'b0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_sel_o   <= sel_nxt;
            bus_wdata_o <= bwdata_nxt;
            op_q        <= mem_op_i;
            off_q       <= mem_addr_i[1:0];
            wd_q        <= wd_i;
            wreg_q      <= wreg_i;
          end
        end
        BUSY: begin
          if (done) begin
            bus_req_o <= 1'b0;
            wd_o      <= wd_q;
            wreg_o    <= is_load_q ? wreg_q : 1'b0;
            if (is_load_q) wdata_o <= load_data;
          end else if (timeout_hit) begin
            bus_req_o   <= 1'b0;
            wreg_o      <= 1'b0;
            align_err_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized ops against a behavioural model.
// Define BUS_TIMEOUT_EN to build the DUT with a 4-cycle watchdog and run the timeout scenario.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        stall_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        align_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef BUS_TIMEOUT_EN
  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_access_stage dut (
`endif
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .stall_o(stall_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .align_err_o(align_err_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  // Reference model helpers, written from the access rules with plain arithmetic
  function automatic int op_size(input int op);
    case (op)
      1, 2, 6: return 1;
      3, 4, 7: return 2;
      5, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_sel(input int op, input logic [31:0] addr);
    int size = op_size(op);
    int off  = int'(addr % 4);
    if (size == 1) return 4'(1 << (3 - off));
    if (size == 2) return (off < 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_store(input int op, input logic [31:0] d);
    if (op == 6) return 32'(d % 256) * 32'h0101_0101;
    if (op == 7) return 32'(d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input int op, input logic [31:0] addr, input logic [31:0] rd);
    int off = int'(addr % 4);
    logic [31:0] b = (rd >> (8 * (3 - off))) % 256;
    logic [31:0] h = (rd >> (16 * (1 - off / 2))) % 65536;
    case (op)
      1: return (b >= 128) ? b - 256 : b;
      2: return b;
      3: return (h >= 32768) ? h - 65536 : h;
      4: return h;
      default: return rd;
    endcase
  endfunction

  task automatic set_idle_inputs();
    valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    mem_op_i = '0; mem_addr_i = '0; mem_data_i = '0;
    bus_rdata_i = '0; bus_ack_i = 1'b0;
  endtask

  // One complete transaction: present, check stall, run the bus handshake, check writeback
  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input int ack_dly, input logic [31:0] rdata, input string tag);
    int  size  = op_size(op);
    bit  is_mem = (size != 0);
    bit  is_ld  = (op >= 1 && op <= 5);
    bit  ok     = is_mem && (addr % size == 0);
    logic [42:0] got, exp;
    @(negedge clk);
    valid_i = 1'b1; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    mem_op_i = 4'(op); mem_addr_i = addr; mem_data_i = sdata;
    #1;
    n_tests++;
    if ({stall_o, bus_req_o} !== {ok, 1'b0}) begin
      n_fail++;
      $display("FAIL %s present: stall/req=%b expected %b", tag, {stall_o, bus_req_o}, {ok, 1'b0});
    end
    @(posedge clk); #1;
    if (!is_mem) begin
      n_tests++;
      got = {wd_o, wreg_o, wdata_o, align_err_o, bus_req_o, stall_o, 3'b000};
      exp = {wd, wreg, wdata, 6'b000000};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s pass: got=%h expected=%h", tag, got, exp);
      end
    end else if (!ok) begin
      n_tests++;
      if ({wreg_o, align_err_o, bus_req_o, stall_o} !== 4'b0100) begin
        n_fail++;
        $display("FAIL %s misalign: wreg/err/req/stall=%b expected 0100", tag,
                 {wreg_o, align_err_o, bus_req_o, stall_o});
      end
      valid_i = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({align_err_o, wreg_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s err pulse: err/wreg=%b expected 00", tag, {align_err_o, wreg_o});
      end
    end else begin
      n_tests++;
      got = {bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, 5'b0};
      exp = {1'b1, !is_ld, addr & 32'hFFFF_FFFC, model_sel(op, addr), 5'b0};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s bus: req/we/addr/sel=%h expected %h", tag, got, exp);
      end
      if (!is_ld) begin
        n_tests++;
        if (bus_wdata_o !== model_store(op, sdata)) begin
          n_fail++;
          $display("FAIL %s bus_wdata: got=%h expected=%h", tag, bus_wdata_o, model_store(op, sdata));
        end
      end
      for (int k = 0; k <= ack_dly; k++) begin
        @(negedge clk);
        bus_ack_i   = (k == ack_dly);
        bus_rdata_i = (k == ack_dly) ? rdata : $urandom;
        #1;
        n_tests++;
        if ({bus_req_o, stall_o} !== {1'b1, k != ack_dly}) begin
          n_fail++;
          $display("FAIL %s busy cyc %0d: req/stall=%b expected %b", tag, k,
                   {bus_req_o, stall_o}, {1'b1, k != ack_dly});
        end
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
      end
      n_tests++;
      if (is_ld) begin
        got = {bus_req_o, wd_o, wreg_o, wdata_o, 4'b0};
        exp = {1'b0, wd, wreg, model_load(op, addr, rdata), 4'b0};
      end else begin
        got = {bus_req_o, wreg_o, 41'b0};
        exp = '0;
      end
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s complete: got=%h expected=%h", tag, got, exp);
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    set_idle_inputs();
    rst = 1'b0;
    valid_i = 1'b1; mem_op_i = 4'd5;
    #12;
    n_tests++;
    if ({stall_o, wd_o, wreg_o, wdata_o, align_err_o, bus_req_o, bus_we_o,
         bus_addr_o, bus_sel_o, bus_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset: outputs not all zero (stall=%b req=%b wreg=%b)", stall_o, bus_req_o, wreg_o);
    end
    @(negedge clk);
    set_idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_alu_pass();
    run_op(0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 32'h0, "alu_pass");
    run_op(12, 32'h3, 32'h0, 5'd17, 1'b1, 32'hCAFE_0001, 0, 32'h0, "op12_none");
  endtask

  task automatic test_bubble();
    run_op(0, 32'h0, 32'h0, 5'd9, 1'b1, 32'hA5A5_5A5A, 0, 32'h0, "pre_bubble");
    @(negedge clk);
    valid_i = 1'b0; wd_i = 5'd3; wdata_i = 32'h1111_1111; wreg_i = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({wd_o, wreg_o, wdata_o} !== {5'd9, 1'b0, 32'hA5A5_5A5A}) begin
      n_fail++;
      $display("FAIL bubble: wd/wreg/wdata=%h expected %h", {wd_o, wreg_o, wdata_o},
               {5'd9, 1'b0, 32'hA5A5_5A5A});
    end
  endtask

  task automatic test_loads_stores();
    run_op(1, 32'h103, 32'h0, 5'd2, 1'b1, 32'h0, 3, 32'h0000_00F0, "lb_103");
    run_op(4, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0, 0, 32'h1234_ABCD, "lhu_102");
    run_op(7, 32'h200, 32'h0000_BEEF, 5'd6, 1'b1, 32'h0, 1, 32'h0, "sh_200");
    run_op(3, 32'h200, 32'h0, 5'd7, 1'b1, 32'h0, 2, 32'h8001_7FFF, "lh_200");
    run_op(5, 32'h300, 32'h0, 5'd8, 1'b1, 32'h0, 0, 32'hDEAD_BEEF, "lw_300");
    run_op(6, 32'h301, 32'h0000_0077, 5'd1, 1'b1, 32'h0, 0, 32'h0, "sb_301");
  endtask

  task automatic test_misaligned();
    run_op(5, 32'h102, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'h0, "lw_102");
    run_op(7, 32'h201, 32'h0, 5'd3, 1'b1, 32'h0, 0, 32'h0, "sh_201");
  endtask

  task automatic test_back_to_back();
    run_op(5, 32'h40, 32'h0, 5'd10, 1'b1, 32'h0, 0, 32'h0102_0304, "b2b_lw");
    run_op(8, 32'h44, 32'h5566_7788, 5'd11, 1'b0, 32'h0, 0, 32'h0, "b2b_sw");
    run_op(2, 32'h46, 32'h0, 5'd12, 1'b1, 32'h0, 0, 32'h0102_8384, "b2b_lbu");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int op = $urandom_range(0, 15);
      logic [31:0] addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_op(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom,
             $urandom_range(0, 3), $urandom, $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h500; wd_i = 5'd2; wreg_i = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy setup: req=%b expected 1", bus_req_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({stall_o, wd_o, wreg_o, wdata_o, align_err_o, bus_req_o, bus_we_o,
         bus_addr_o, bus_sel_o, bus_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_busy: outputs not all zero (stall=%b req=%b)", stall_o, bus_req_o);
    end
    @(negedge clk);
    set_idle_inputs();
    rst = 1'b1;
    run_op(4, 32'h502, 32'h0, 5'd6, 1'b1, 32'h0, 0, 32'h0000_F00D, "after_rst");
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h600; wd_i = 5'd4; wreg_i = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_tests++;
      if ({bus_req_o, stall_o} !== {1'b1, k != 3}) begin
        n_fail++;
        $display("FAIL timeout cyc %0d: req/stall=%b expected %b", k, {bus_req_o, stall_o}, {1'b1, k != 3});
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    n_tests++;
    if ({bus_req_o, wreg_o, align_err_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL timeout end: req/wreg/err=%b expected 001", {bus_req_o, wreg_o, align_err_o});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_pass();
    test_bubble();
    test_loads_stores();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
